// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, line idle level, length clamp.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Zero or over-range lengths fall back to the full word width.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/ser_parity_gen.sv
// Masked XOR reduction: parity over the low 'len' bits of 'data'.
module ser_parity_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [LEN_W-1:0]      len,
  output logic                  parity_c
);

  // XOR only the bits that fall inside the active length.
  always_comb begin
    parity_c = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (LEN_W'(i) < len) parity_c = parity_c ^ data[i];
    end
  end

endmodule

// File: rtl/param_serializer.sv
// Parametrised TX serializer: loads a word over valid/ready, shifts out a
// runtime-selected number of bits on TX_tick, pulses ser_done on the last bit.
// Optional trailing parity bit enabled by defining SER_PARITY_EN.
module param_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0,
  localparam int unsigned LEN_W     = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_tick,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic [LEN_W-1:0]      DATA_LEN,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_SHIFT = 2'(SHIFT);
`ifdef SER_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'(PARITY);
`endif

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  ser_data_q, ser_data_d;
  logic                  ser_done_q, ser_done_d;
  logic                  busy_q, busy_d;

  logic [LEN_W-1:0]      eff_len_c;
  logic [DATA_WIDTH-1:0] load_word_c;
  logic                  next_bit_c;
  logic [DATA_WIDTH-1:0] shifted_c;
  logic                  last_bit_c;

`ifdef SER_PARITY_EN
  logic parity_q, parity_d, parity_c;

  ser_parity_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_W      (LEN_W)
  ) u_parity_gen (
    .data     (TX_DATA),
    .len      (eff_len_c),
    .parity_c (parity_c)
  );
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Shift-path helpers; MSB-first words are left-aligned at load so the
  // outgoing bit is always at the top of the register.
  always_comb begin
    eff_len_c  = LEN_W'(eff_len(32'(DATA_LEN), DATA_WIDTH));
    last_bit_c = (cnt_q == (len_q - LEN_W'(1)));
    if (LSB_FIRST) begin
      load_word_c = TX_DATA;
      next_bit_c  = shreg_q[0];
      shifted_c   = shreg_q >> 1;
    end else begin
      load_word_c = TX_DATA << (LEN_W'(DATA_WIDTH) - eff_len_c);
      next_bit_c  = shreg_q[DATA_WIDTH-1];
      shifted_c   = shreg_q << 1;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ser_data_d = ser_data_q;
    ser_done_d = 1'b0;
    busy_d     = busy_q;
`ifdef SER_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          shreg_d = load_word_c;
          len_d   = eff_len_c;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef SER_PARITY_EN
          parity_d = parity_c ^ PARITY_ODD;
`endif
        end
      end
      S_SHIFT: begin
        if (TX_tick) begin
          ser_data_d = next_bit_c;
          shreg_d    = shifted_c;
          cnt_d      = cnt_q + LEN_W'(1);
          if (last_bit_c) begin
`ifdef SER_PARITY_EN
            state_d    = S_PARITY;
`else
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            ser_done_d = 1'b1;
`endif
          end
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (TX_tick) begin
          ser_data_d = parity_q;
          ser_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ser_data_q <= UART_IDLE_LEVEL;
      ser_done_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ser_data_q <= ser_data_d;
      ser_done_q <= ser_done_d;
      busy_q     <= busy_d;
`ifdef SER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign ser_data   = ser_data_q;
  assign ser_done   = ser_done_q;
  assign busy       = busy_q;

endmodule
